// File: rtl/mem_initiator_pkg.sv
// mem_initiator_pkg: shared state encoding and memory/burst constants
package mem_initiator_pkg;
  localparam int MEM_DEPTH = 4097;
  localparam int MAX_BURST = 16;
  localparam int WORD_W    = 32;
  localparam int ADDR_BITS = 32;
  localparam int LEN_BITS  = 5;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_DONE, S_ERR} state_e;
endpackage

// File: rtl/mem_initiator_if.sv
// mem_initiator_if: command, read/write stream and memory bus between core, initiator and memory
//   command : req_valid/req_ready/req_we/req_addr/req_len
//   write   : wr_valid/wr_ready/wr_data      read : rd_valid/rd_ready/rd_data
//   status  : busy/done/err                  memory : mem_w/mem_addr/mem_w_v/mem_r_v
interface mem_initiator_if
  import mem_initiator_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = ADDR_BITS,
  parameter int LEN_W  = LEN_BITS
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              mem_w;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_w_v;
  logic [DATA_W-1:0] mem_r_v;
  modport master (
    input  req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_r_v,
    output req_ready, wr_ready, rd_valid, rd_data, busy, done, err, mem_w, mem_addr, mem_w_v
  );
  modport slave (
    output req_valid, req_we, req_addr, req_len, wr_valid, wr_data, rd_ready, mem_r_v,
    input  req_ready, wr_ready, rd_valid, rd_data, busy, done, err, mem_w, mem_addr, mem_w_v
  );
endinterface

// File: rtl/mem_initiator_range_check.sv
// mem_range_check: combinational legality test of a burst (addr, len) against memory depth and max length
//   i_addr : first word address    i_len : burst length    o_ok : 1 when the whole burst is legal
module mem_range_check #(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 5,
  parameter int DEPTH   = 4097,
  parameter int MAX_LEN = 16
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic              o_ok
);
  // one extra bit so addr+len-1 cannot wrap past the top of the address space
  logic [ADDR_W:0] w_end;
  assign w_end = {1'b0, i_addr} + (ADDR_W+1)'(i_len) - 1'b1;
  assign o_ok  = (i_len != '0) & (i_len <= LEN_W'(MAX_LEN)) & (w_end <= (ADDR_W+1)'(DEPTH - 1));
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: burst bus master sequencing word reads/writes on a single-port memory
//   clk, rst : clock and synchronous active-high reset
//   bus      : command, read/write streams, status pulses and memory port (master view)
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int DATA_W  = WORD_W,
  parameter int ADDR_W  = ADDR_BITS,
  parameter int DEPTH   = MEM_DEPTH,
  parameter int MAX_LEN = MAX_BURST,
  parameter int LEN_W   = LEN_BITS
) (
  input logic clk,
  input logic rst,
  mem_initiator_if.master bus
);
  state_e            r_state, w_next;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [LEN_W-1:0]  r_rem, w_rem_nx;
  logic              w_ok, w_fire, w_last;
  mem_range_check #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)
  ) u_range (
    .i_addr(bus.req_addr), .i_len(bus.req_len), .o_ok(w_ok)
  );
  assign w_fire = (r_state == S_RD & bus.rd_ready) | (r_state == S_WR & bus.wr_valid);
  assign w_last = r_rem == LEN_W'(1);
  // cur_addr is not advanced past the last word so mem_addr stays in range and holds it afterwards;
  // rejected commands leave cur_addr untouched for the same reason
  always_comb begin
    w_next    = r_state;
    w_addr_nx = r_addr;
    w_rem_nx  = r_rem;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        w_next    = w_ok ? (bus.req_we ? S_WR : S_RD) : S_ERR;
        w_addr_nx = w_ok ? bus.req_addr : r_addr;
        w_rem_nx  = w_ok ? bus.req_len : r_rem;
      end
      S_RD, S_WR: if (w_fire) begin
        w_next    = w_last ? S_DONE : r_state;
        w_addr_nx = w_last ? r_addr : r_addr + 1'b1;
        w_rem_nx  = r_rem - 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_nx;
      r_rem   <= w_rem_nx;
    end
  end
  assign bus.req_ready = (r_state == S_IDLE) & ~rst;
  assign bus.busy      = r_state != S_IDLE;
  assign bus.done      = r_state == S_DONE;
  assign bus.err       = r_state == S_ERR;
  assign bus.rd_valid  = r_state == S_RD;
  assign bus.rd_data   = bus.mem_r_v;
  assign bus.wr_ready  = r_state == S_WR;
  // gated by rst so a write in flight never commits once reset is asserted
  assign bus.mem_w     = bus.wr_valid & (r_state == S_WR) & ~rst;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_w_v   = bus.wr_data;
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized self-checking bench for mem_initiator against a burst-level reference model
module tb_mem_initiator;
  import mem_initiator_pkg::*;
  localparam int DEPTH = MEM_DEPTH;
  localparam int MAXC  = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int n_mem_w = 0;
  int exp_ma = 0;
  logic [31:0] mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  mem_initiator_if bus ();
  mem_initiator dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.mem_r_v = (bus.mem_addr < DEPTH) ? mem[bus.mem_addr[12:0]] : '0;
  always @(negedge clk) if (bus.mem_w) begin
    if (bus.mem_addr < DEPTH) mem[bus.mem_addr[12:0]] = bus.mem_w_v;
    n_mem_w++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // issue one command and follow it to completion; pat bit c gives wr_valid/rd_ready in burst cycle c
  task automatic do_cmd(input logic we, input int addr, input int len, input logic [31:0] pat,
                        input bit seq, input int rst_at);
    bit legal;
    int k, c, w0;
    logic b;
    legal = len >= 1 && len <= MAX_BURST && (longint'(addr) + len - 1) <= DEPTH - 1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = 5'(len);
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    step();
    bus.req_valid = 1'b0;
    w0 = n_mem_w;
    if (!legal) begin
      @(negedge clk);
      check("err_pulse", bus.err, 1);
      check("err_no_done", bus.done, 0);
      check("err_busy", bus.busy, 1);
      check("err_mem_addr_hold", bus.mem_addr, exp_ma);
      step();
      @(negedge clk);
      check("err_one_cycle", bus.err, 0);
      check("err_idle_ready", bus.req_ready, 1);
      check("err_no_mem_w", n_mem_w - w0, 0);
      step();
      return;
    end
    k = 0;
    c = 0;
    while (k < len && c < MAXC) begin
      b = (c < 32) ? pat[c] : 1'b1;
      bus.req_valid = 1'($urandom);
      bus.req_addr  = $urandom;
      if (we && rst_at == k) begin
        rst = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = $urandom;
        @(negedge clk);
        check("rst_mem_w_gated", bus.mem_w, 0);
        check("rst_req_ready", bus.req_ready, 0);
        step();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        bus.wr_valid  = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.req_ready, 1);
        check("rst_no_done", bus.done, 0);
        check("rst_no_err", bus.err, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        exp_ma = 0;
        step();
        return;
      end
      if (we) begin
        bus.wr_valid = b;
        bus.wr_data  = seq ? 32'hA + 32'(k) : $urandom;
      end else bus.rd_ready = b;
      @(negedge clk);
      check("busy_ready_low", bus.req_ready, 0);
      check("burst_addr", bus.mem_addr, addr + k);
      if (we) begin
        check("wr_ready", bus.wr_ready, 1);
        check("wr_strobe", bus.mem_w, b);
        if (b) ref_mem[addr + k] = bus.wr_data;
      end else begin
        check("rd_valid", bus.rd_valid, 1);
        check("rd_data", bus.rd_data, ref_mem[addr + k]);
      end
      if (b) k++;
      c++;
      step();
    end
    if (k < len) check("burst_timeout", k, len);
    bus.req_valid = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    @(negedge clk);
    check("done_pulse", bus.done, 1);
    check("done_no_err", bus.err, 0);
    check("done_no_stream", {bus.mem_w, bus.rd_valid, bus.wr_ready, bus.req_ready}, 0);
    check("wr_count", n_mem_w - w0, we ? len : 0);
    step();
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("idle_ready", bus.req_ready, 1);
    check("mem_addr_hold", bus.mem_addr, addr + len - 1);
    exp_ma = addr + len - 1;
    step();
  endtask
  initial begin
    int bad, a;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = 32'(i * 7 + 3);
      ref_mem[i] = 32'(i * 7 + 3);
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    @(negedge clk);
    check("in_rst_ready", bus.req_ready, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", {bus.req_ready, bus.busy, bus.done, bus.err, bus.rd_valid, bus.wr_ready, bus.mem_w}, 7'b1000000);
    check("rst_addr", bus.mem_addr, 0);
    step();
    do_cmd(1'b1, 10, 4, '1, 1'b1, -1);
    do_cmd(1'b0, 10, 4, '1, 1'b0, -1);
    do_cmd(1'b0, 10, 2, 32'hFFFF_FFF8, 1'b0, -1);
    do_cmd(1'b1, 20, 3, 32'h0000_0019, 1'b0, -1);
    do_cmd(1'b1, 50, 0, '1, 1'b0, -1);
    do_cmd(1'b1, 50, 17, '1, 1'b0, -1);
    do_cmd(1'b1, 4094, 4, '1, 1'b0, -1);
    do_cmd(1'b0, 4094, 4, '1, 1'b0, -1);
    do_cmd(1'b1, 4093, 4, '1, 1'b0, -1);
    do_cmd(1'b0, 4093, 4, 32'h5555_5555, 1'b0, -1);
    do_cmd(1'b1, 100, 5, '1, 1'b0, 2);
    check("rst_word3_kept", mem[102], 102 * 7 + 3);
    check("rst_word5_kept", mem[104], 104 * 7 + 3);
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4080, 4100)) : int'($urandom_range(0, 4096));
      do_cmd(1'($urandom), a, int'($urandom_range(0, 18)), $urandom, 1'b0, -1);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_contents", bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
